// File: rtl/assgn1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : assgn1_pkg
//  Description : Shared constants and helpers for the assgn1 full-adder cell.
//  Revision    : 1.0  initial release
// ============================================================================
package assgn1_pkg;

    // Default width of the saturating carry-event counter
    localparam int CNT_W_DEF = 8;

    // Majority of three bits: carry-out of a 1-bit full adder
    function automatic logic fa_maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : assgn1_pkg
`default_nettype wire

// File: rtl/assgn1_fa_cell.sv
`default_nettype none
// ============================================================================
//  Module      : assgn1_fa_cell
//  Description : Purely combinational 1-bit full adder (a + b + cin).
//  Revision    : 1.0  initial release
// ============================================================================
module assgn1_fa_cell
    import assgn1_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);

    // Sum is the parity of the three inputs, carry their majority
    always_comb begin
        o_sum   = i_a ^ i_b ^ i_cin;
        o_carry = fa_maj(i_a, i_b, i_cin);
    end

endmodule : assgn1_fa_cell
`default_nettype wire

// File: rtl/assgn1.sv
`default_nettype none
// ============================================================================
//  Module      : assgn1
//  Description : 1-bit full adder with zero-latency outputs, registered
//                copies of sum/carry and a saturating carry-event counter.
//                Optional macro ASSGN1_SERIAL_EN adds a 'serial' input that
//                feeds carry_q back as carry-in, forming a bit-serial adder.
//  Revision    : 1.0  initial release
// ============================================================================
module assgn1
    import assgn1_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ASSGN1_SERIAL_EN
    input  logic             serial,
`endif
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             cnt_sat
);

    logic             w_cin;
    logic             w_sum;
    logic             w_carry;
    logic             w_sat;
    logic             r_sum_q;
    logic             r_carry_q;
    logic [CNT_W-1:0] r_cnt;

    // Carry-in select: in serial mode the previous bit's carry replaces c
`ifdef ASSGN1_SERIAL_EN
    always_comb begin
        w_cin = serial ? r_carry_q : c;
    end
`else
    always_comb begin
        w_cin = c;
    end
`endif

    assgn1_fa_cell u_fa (
        .i_a     (a),
        .i_b     (b),
        .i_cin   (w_cin),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Counter is full when every bit is set; it must hold there, not wrap
    always_comb begin
        w_sat = &r_cnt;
    end

    // One-cycle registered copies of sum and carry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_q   <= 1'b0;
            r_carry_q <= 1'b0;
        end else begin
            r_sum_q   <= w_sum;
            r_carry_q <= w_carry;
        end
    end

    // Count edges at which carry is high; reset takes priority over counting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_carry && !w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Combinational outputs are never gated by reset
    always_comb begin
        sum       = w_sum;
        carry     = w_carry;
        sum_q     = r_sum_q;
        carry_q   = r_carry_q;
        carry_cnt = r_cnt;
        cnt_sat   = w_sat;
    end

endmodule : assgn1
`default_nettype wire

// File: tb/tb_assgn1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_assgn1
//  Description : Directed self-checking bench for assgn1 (default CNT_W and
//                a CNT_W=3 instance for saturation). Serial-mode steps are
//                included when ASSGN1_SERIAL_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_assgn1;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       c;
`ifdef ASSGN1_SERIAL_EN
    logic       serial;
`endif
    logic       sum;
    logic       carry;
    logic       sum_q;
    logic       carry_q;
    logic [7:0] carry_cnt;
    logic       cnt_sat;

    logic       sum3;
    logic       carry3;
    logic       sum_q3;
    logic       carry_q3;
    logic [2:0] carry_cnt3;
    logic       cnt_sat3;

    int total;
    int bad;

    assgn1 u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ASSGN1_SERIAL_EN
        .serial    (serial),
`endif
        .a         (a),
        .b         (b),
        .c         (c),
        .sum       (sum),
        .carry     (carry),
        .sum_q     (sum_q),
        .carry_q   (carry_q),
        .carry_cnt (carry_cnt),
        .cnt_sat   (cnt_sat)
    );

    assgn1 #(.CNT_W(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
`ifdef ASSGN1_SERIAL_EN
        .serial    (serial),
`endif
        .a         (a),
        .b         (b),
        .c         (c),
        .sum       (sum3),
        .carry     (carry3),
        .sum_q     (sum_q3),
        .carry_q   (carry_q3),
        .carry_cnt (carry_cnt3),
        .cnt_sat   (cnt_sat3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic vb, input logic vc);
        a = va;
        b = vb;
        c = vc;
    endtask

    initial begin
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] stream;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
`ifdef ASSGN1_SERIAL_EN
        serial = 1'b0;
`endif
        drive(1'b0, 1'b0, 1'b0);

        // Truth table, checked while reset is asserted
        #5; chk("tt000_sum", 32'(sum), 0); chk("tt000_carry", 32'(carry), 0);
        drive(1'b0, 1'b1, 1'b0);
        #5; chk("tt010_sum", 32'(sum), 1); chk("tt010_carry", 32'(carry), 0);
        drive(1'b1, 1'b0, 1'b1);
        #5; chk("tt101_sum", 32'(sum), 0); chk("tt101_carry", 32'(carry), 1);
        drive(1'b1, 1'b1, 1'b1);
        #5; chk("tt111_sum", 32'(sum), 1); chk("tt111_carry", 32'(carry), 1);

        // Reset for two edges
        tick(); tick();
        chk("rst_sum_q", 32'(sum_q), 0);
        chk("rst_carry_q", 32'(carry_q), 0);
        chk("rst_cnt", 32'(carry_cnt), 0);
        chk("rst_sat", 32'(cnt_sat), 0);
        chk("rst_cnt3", 32'(carry_cnt3), 0);

        // Registered path: 1,0,1 -> 0/1 one edge later
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        #1;
        chk("reg_pre_sum_q", 32'(sum_q), 0);
        chk("reg_pre_carry_q", 32'(carry_q), 0);
        tick();
        chk("reg_sum_q", 32'(sum_q), 0);
        chk("reg_carry_q", 32'(carry_q), 1);
        chk("reg_cnt", 32'(carry_cnt), 1);

        // Counter: 10 edges of 1,1,0 then 5 edges of 0,0,0
        rst = 1'b1; tick(); rst = 1'b0;
        chk("cnt_clr", 32'(carry_cnt), 0);
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("cnt_10", 32'(carry_cnt), 10);
        chk("cnt_10_sat", 32'(cnt_sat), 0);
        chk("cnt_10_sum_q", 32'(sum_q), 0);
        chk("cnt3_held", 32'(carry_cnt3), 7);
        chk("cnt3_sat", 32'(cnt_sat3), 1);
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_hold", 32'(carry_cnt), 10);

        // Reset mid-count
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_cnt5", 32'(carry_cnt), 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_carry", 32'(carry), 1);
        chk("mid_rst_sum", 32'(sum), 0);
        tick();
        chk("mid_cnt0", 32'(carry_cnt), 0);
        chk("mid_sum_q", 32'(sum_q), 0);
        chk("mid_carry_q", 32'(carry_q), 0);
        drive(1'b0, 1'b1, 1'b0);
        #1;
        chk("mid_rst_sum2", 32'(sum), 1);
        chk("mid_rst_carry2", 32'(carry), 0);
        tick();
        rst = 1'b0;

        // Saturation on the 3-bit instance
        drive(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("sat_cnt_e%0d", k), 32'(carry_cnt3), (k < 7) ? k : 7);
            chk($sformatf("sat_flag_e%0d", k), 32'(cnt_sat3), (k >= 7) ? 1 : 0);
        end
        chk("sat_wide_cnt", 32'(carry_cnt), 9);

`ifdef ASSGN1_SERIAL_EN
        // Serial 11 + 6, LSB first; c driven high to show it is ignored
        rst = 1'b1; tick(); rst = 1'b0;
        serial = 1'b1;
        sa = 4'b1011;
        sb = 4'b0110;
        stream = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            drive(sa[i], sb[i], 1'b1);
            tick();
            stream[i] = sum_q;
        end
        chk("ser_stream", 32'(stream), 1);
        chk("ser_carry_q", 32'(carry_q), 1);
        serial = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_assgn1
`default_nettype wire
